tmr_majority_voter: RTL and testbench

Parametrised N-channel, W-bit bitwise majority voter. It is the sequential successor to the 3-input majority expression Y = AB + BC + CA. Each bit of the output is the majority of that bit across N_CH redundant channels, and the output is registered with a valid strobe. Per-channel disagreement tracking, saturating error counters and sticky fault flags let the system identify a failing replica.

---
 rtl/tmr_majority_voter.sv | 141 ++++++++++++++
 tb/tb_tmr_majority_voter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_majority_voter.sv
// N_CH-way bitwise majority voter with a registered output, per-channel
// saturating mismatch counters and sticky fault flags.
module tmr_majority_voter #(
   parameter int N_CH     = 3,
   parameter int WIDTH    = 8,
   parameter int CNT_W    = 8,
   parameter int FAULT_TH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   input  logic                    clr_cnt,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [N_CH-1:0]         mismatch,
   output logic [N_CH-1:0]         fault,
   output logic [N_CH*CNT_W-1:0]   err_cnt
);

   // Per-channel tracker states
   // state       | meaning
   // ST_OK       | channel agreed with the vote on its last valid sample
   // ST_SUSPECT  | channel is in a run of consecutive valid mismatches
   // ST_FAULTED  | run reached FAULT_TH; held until rst or clr_cnt
   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULTED = 2'd2
   } ch_state_t;

   localparam logic [7:0] TH_M1 = 8'(FAULT_TH - 1);

   if (N_CH < 3 || N_CH > 7 || (N_CH % 2) == 0) begin : g_bad_n_ch
      $error("tmr_majority_voter: N_CH must be odd and within 3..7");
   end
   if (FAULT_TH < 1 || FAULT_TH > 255) begin : g_bad_fault_th
      $error("tmr_majority_voter: FAULT_TH must be within 1..255");
   end

   logic [WIDTH-1:0] voted;
   logic [N_CH-1:0]  mis_vec;

   always_comb begin
      voted = '0;
      for (int b = 0; b < WIDTH; b++) begin
         logic [3:0] ones;
         ones = '0;
         for (int k = 0; k < N_CH; k++) begin
            ones = ones + 4'(in_data[k*WIDTH + b]);
         end
         voted[b] = (ones > 4'(N_CH / 2));
      end
   end

   // out_data is only loaded on valid samples so idle-cycle X cannot leak out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         mismatch  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= voted;
            mismatch <= mis_vec;
         end else begin
            mismatch <= '0;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      ch_state_t        state_q, state_d;
      logic [7:0]       remain_q, remain_d;
      logic [CNT_W-1:0] cnt_q;
      logic             mis;

      assign mis = |(in_data[k*WIDTH +: WIDTH] ^ voted);
      assign mis_vec[k] = mis;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q  <= ST_OK;
            remain_q <= '0;
         end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
         end
      end

      // remain_q counts down the mismatches still needed to reach FAULTED
      always_comb begin
         state_d  = state_q;
         remain_d = remain_q;
         if (clr_cnt) begin
            state_d  = ST_OK;
            remain_d = '0;
         end else if (in_valid) begin
            case (state_q)
               ST_OK: begin
                  if (mis) begin
                     if (FAULT_TH == 1) begin
                        state_d = ST_FAULTED;
                     end else begin
                        state_d  = ST_SUSPECT;
                        remain_d = TH_M1;
                     end
                  end
               end
               ST_SUSPECT: begin
                  if (!mis) begin
                     state_d  = ST_OK;
                     remain_d = '0;
                  end else if (remain_q == 8'd1) begin
                     state_d  = ST_FAULTED;
                     remain_d = '0;
                  end else begin
                     remain_d = remain_q - 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (clr_cnt) begin
            cnt_q <= '0;
         end else if (in_valid && mis && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign fault[k]                   = (state_q == ST_FAULTED);
      assign err_cnt[k*CNT_W +: CNT_W]  = cnt_q;
   end

endmodule

// File: tb/tb_tmr_majority_voter.sv
// Directed and randomized checks of tmr_majority_voter (N_CH=3, WIDTH=8,
// CNT_W=8, FAULT_TH=4) against a per-sample behavioural model.
module tb_tmr_majority_voter;

   localparam int N  = 3;
   localparam int W  = 8;
   localparam int CW = 8;
   localparam int TH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic [N*W-1:0]  in_data = '0;
   logic            clr_cnt = 1'b0;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [N-1:0]    mismatch;
   logic [N-1:0]    fault;
   logic [N*CW-1:0] err_cnt;

   tmr_majority_voter #(.N_CH(N), .WIDTH(W), .CNT_W(CW), .FAULT_TH(TH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .clr_cnt(clr_cnt), .out_valid(out_valid), .out_data(out_data),
      .mismatch(mismatch), .fault(fault), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_chk = 0;

   logic         m_valid;
   logic [W-1:0] m_data;
   logic [N-1:0] m_mis;
   logic [N-1:0] m_fault;
   int           m_cnt[N];
   int           m_run[N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_mis = '0; m_fault = '0;
      for (int k = 0; k < N; k++) begin m_cnt[k] = 0; m_run[k] = 0; end
   endtask

   // Majority by counting set bits per column; run length tracked as a plain integer.
   task automatic model_step(input logic v, input logic [N*W-1:0] d, input logic c);
      logic [W-1:0] vote;
      logic [N-1:0] mis;
      vote = '0;
      mis  = '0;
      for (int b = 0; b < W; b++) begin
         int ones = 0;
         for (int k = 0; k < N; k++) ones += int'(d[k*W + b]);
         vote[b] = (ones * 2 > N);
      end
      for (int k = 0; k < N; k++) mis[k] = (d[k*W +: W] != vote);
      m_valid = v;
      if (v) begin m_data = vote; m_mis = mis; end
      else m_mis = '0;
      for (int k = 0; k < N; k++) begin
         if (c) begin
            m_cnt[k] = 0; m_run[k] = 0; m_fault[k] = 1'b0;
         end else if (v && !m_fault[k]) begin
            m_run[k] = mis[k] ? m_run[k] + 1 : 0;
            if (m_run[k] >= TH) m_fault[k] = 1'b1;
         end
         if (!c && v && mis[k]) m_cnt[k] = (m_cnt[k] + 1 > 255) ? 255 : m_cnt[k] + 1;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".out_data"},  32'(out_data),  32'(m_data));
      check({tag, ".mismatch"},  32'(mismatch),  32'(m_mis));
      check({tag, ".fault"},     32'(fault),     32'(m_fault));
      for (int k = 0; k < N; k++)
         check($sformatf("%s.err_cnt%0d", tag, k), 32'(err_cnt[k*CW +: CW]), 32'(m_cnt[k]));
   endtask

   task automatic step(input string tag, input logic v, input logic [N*W-1:0] d, input logic c);
      @(negedge clk);
      in_valid = v; in_data = d; clr_cnt = c;
      model_step(v, d, c);
      @(posedge clk);
      #1;
      n_vec++;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [N*W-1:0] pk(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
      return {c2, c1, c0};
   endfunction

   initial begin
      logic [N*W-1:0] rd;
      logic [7:0]     good;

      // 1. asynchronous reset, before any clock edge
      model_reset();
      #2 rst = 1'b1;
      #1;
      check_all("reset");
      @(negedge clk); rst = 1'b0;

      // 2. agreement
      step("agree", 1'b1, pk(8'hA5, 8'hA5, 8'hA5), 1'b0);
      check("agree.data", 32'(out_data), 32'h A5);
      check("agree.mis",  32'(mismatch), 32'h0);
      step("agree_idle", 1'b0, pk(8'h12, 8'h34, 8'h56), 1'b0);
      check("agree_idle.hold", 32'(out_data), 32'h A5);

      // 3. bitwise vote
      step("bitwise", 1'b1, pk(8'hFF, 8'h0F, 8'hF0), 1'b0);
      check("bitwise.data", 32'(out_data), 32'h FF);
      check("bitwise.mis",  32'(mismatch), 32'b110);

      // 4. fault detection with an idle gap
      do_reset();
      step("flt1", 1'b1, pk(8'h3C, 8'h3C, 8'h00), 1'b0);
      step("flt2", 1'b1, pk(8'h3C, 8'h3C, 8'h00), 1'b0);
      step("flt_gap", 1'b0, pk(8'h00, 8'hFF, 8'h55), 1'b0);
      step("flt3", 1'b1, pk(8'h3C, 8'h3C, 8'h00), 1'b0);
      check("flt3.nofault", 32'(fault), 32'b000);
      step("flt4", 1'b1, pk(8'h3C, 8'h3C, 8'h00), 1'b0);
      check("flt4.fault", 32'(fault), 32'b100);
      check("flt4.cnt2", 32'(err_cnt[2*CW +: CW]), 32'd4);
      step("flt5", 1'b1, pk(8'h3C, 8'h3C, 8'h3C), 1'b0);
      check("flt5.sticky", 32'(fault), 32'b100);

      do_reset();
      for (int i = 0; i < 3; i++) step("brk_mis", 1'b1, pk(8'h3C, 8'h3C, 8'h00), 1'b0);
      step("brk_match", 1'b1, pk(8'h3C, 8'h3C, 8'h3C), 1'b0);
      step("brk_mis4", 1'b1, pk(8'h3C, 8'h3C, 8'h00), 1'b0);
      check("brk.nofault", 32'(fault), 32'b000);

      // 5. saturation
      do_reset();
      for (int i = 0; i < 300; i++) step("sat", 1'b1, pk(8'h5A, 8'hA5, 8'h5A), 1'b0);
      check("sat.cnt1", 32'(err_cnt[1*CW +: CW]), 32'd255);
      check("sat.fault", 32'(fault), 32'b010);

      // 6. clear priority over a mismatching sample
      step("clr", 1'b1, pk(8'h11, 8'h22, 8'h11), 1'b1);
      check("clr.mis",   32'(mismatch), 32'b010);
      check("clr.cnt",   32'(err_cnt), 32'h0);
      check("clr.fault", 32'(fault), 32'b000);

      // reset mid-stream with a valid sample pending
      step("pre_rst", 1'b1, pk(8'h77, 8'h70, 8'h77), 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = pk(8'h99, 8'h99, 8'h66); clr_cnt = 1'b0;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_all("midrst_async");
      @(posedge clk); #1;
      check_all("midrst_held");
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         good = 8'($urandom);
         for (int k = 0; k < N; k++)
            rd[k*W +: W] = ($urandom_range(3) == 0) ? 8'($urandom) : good;
         step("rand", ($urandom_range(3) != 0), rd, ($urandom_range(40) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
